seg7_ctrl: RTL and testbench

- Memory-mapped controller that owns the 8-digit seven-segment display datapath.
- Accepts single-outstanding register reads and writes from the core's peripheral bus.
- Holds the display value, per-digit blank mask and control bits, and generates a blink cadence from a prescaler.
- Drives disp_data/disp_blank into seg7_phy.

---
 rtl/seg7_ctrl.sv | 118 +++++++++++
 tb/tb_seg7_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_ctrl.sv
// Register front-end for the 8-digit seven-segment display: single-outstanding
// bus slave, display data/blank registers and a prescaled blink cadence.
module seg7_ctrl #(
  parameter int CLK_HZ   = 100000000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [31:0] disp_data,
  output logic [7:0]  disp_blank
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = $clog2(HALF);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic [31:0]   data_q;
  logic [7:0]    mask_q;
  logic          blink_en;
  logic          hold;
  logic [PW-1:0] presc;
  logic          phase;

  logic          acc, wr;
  logic [1:0]    sel;
  logic          ctrl_wr;
  logic          blink_nxt;
  logic [31:0]   rd_val;
  logic          unused_ok;

  assign unused_ok = ^req_addr[1:0];

  always_comb begin
    acc       = (state == IDLE) && req_valid;
    wr        = acc && req_we;
    sel       = req_addr[3:2];
    ctrl_wr   = wr && (sel == 2'd2) && req_wstrb[0];
    blink_nxt = ctrl_wr ? req_wdata[0] : blink_en;
    rd_val    = '0;
    case (sel)
      2'd0: rd_val = data_q;
      2'd1: rd_val = {24'b0, mask_q};
      2'd2: rd_val = {30'b0, hold, blink_en};
      2'd3: rd_val = {30'b0, hold, phase};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      blink_en   <= 1'b0;
      hold       <= 1'b0;
      presc      <= '0;
      phase      <= 1'b0;
      disp_data  <= '0;
      disp_blank <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state      <= RESP;
          req_ready  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= req_we ? 32'b0 : rd_val;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase

      if (wr && sel == 2'd0) begin
        for (int b = 0; b < 4; b++)
          if (req_wstrb[b]) data_q[8*b +: 8] <= req_wdata[8*b +: 8];
      end
      if (wr && sel == 2'd1 && req_wstrb[0]) mask_q <= req_wdata[7:0];
      if (ctrl_wr) begin
        blink_en <= req_wdata[0];
        hold     <= req_wdata[1];
      end

      // Counting only continues when blink stays enabled across this edge;
      // a disable or a fresh enable restarts the cadence from phase 0.
      if (!blink_en || !blink_nxt) begin
        presc <= '0;
        phase <= 1'b0;
      end else if (presc == PW'(HALF - 1)) begin
        presc <= '0;
        phase <= ~phase;
      end else begin
        presc <= presc + 1'b1;
      end

      if (!hold) disp_data <= data_q;
      disp_blank <= (blink_en && phase) ? 8'hFF : mask_q;
    end
  end

endmodule

// File: tb/tb_seg7_ctrl.sv
// Self-checking bench for seg7_ctrl: table of bus transactions with a
// response scoreboard, plus hand sequences for blink, backpressure and reset.
module tb_seg7_ctrl;

  logic        clk = 0;
  logic        rst;
  logic        req_valid, req_we, resp_ready;
  logic [3:0]  req_addr, req_wstrb;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata, disp_data;
  logic [7:0]  disp_blank;

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [31:0] exp_disp;
    logic [7:0]  exp_blank;
  } vec_t;

  vec_t vecs[16];

  seg7_ctrl #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .disp_data(disp_data), .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction; returns at #1 after the edge where the response retires.
  task automatic xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] exp);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    resp_ready = 1;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    sb.push_back(exp);
    tick();
    req_valid = 0;
    chk("resp_latency", {31'b0, resp_valid}, 32'd1);
    if (resp_valid && sb.size() > 0) chk("resp_rdata", resp_rdata, sb.pop_front());
    tick();
    chk("resp_retire", {30'b0, resp_valid, req_ready}, 32'd1);
    chk("rdata_clear", resp_rdata, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1, 4'h0, 32'h12345678, 4'hF, 32'h0,        32'h12345678, 8'h00};
    vecs[1]  = '{0, 4'h3, 32'h0,        4'h0, 32'h12345678, 32'h12345678, 8'h00};
    vecs[2]  = '{1, 4'h0, 32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF, 8'h00};
    vecs[3]  = '{1, 4'h0, 32'h00000011, 4'h1, 32'h0,        32'hDEADBE11, 8'h00};
    vecs[4]  = '{0, 4'h0, 32'h0,        4'h0, 32'hDEADBE11, 32'hDEADBE11, 8'h00};
    vecs[5]  = '{1, 4'h4, 32'hFFFFFFAB, 4'hF, 32'h0,        32'hDEADBE11, 8'hAB};
    vecs[6]  = '{1, 4'h4, 32'h00000055, 4'hE, 32'h0,        32'hDEADBE11, 8'hAB};
    vecs[7]  = '{0, 4'h4, 32'h0,        4'h0, 32'h000000AB, 32'hDEADBE11, 8'hAB};
    vecs[8]  = '{1, 4'h8, 32'h00000002, 4'h1, 32'h0,        32'hDEADBE11, 8'hAB};
    vecs[9]  = '{1, 4'h0, 32'hCAFE0000, 4'hF, 32'h0,        32'hDEADBE11, 8'hAB};
    vecs[10] = '{0, 4'h0, 32'h0,        4'h0, 32'hCAFE0000, 32'hDEADBE11, 8'hAB};
    vecs[11] = '{0, 4'h8, 32'h0,        4'h0, 32'h00000002, 32'hDEADBE11, 8'hAB};
    vecs[12] = '{1, 4'hC, 32'hFFFFFFFF, 4'hF, 32'h0,        32'hDEADBE11, 8'hAB};
    vecs[13] = '{0, 4'hC, 32'h0,        4'h0, 32'h00000002, 32'hDEADBE11, 8'hAB};
    vecs[14] = '{1, 4'h8, 32'h00000000, 4'h1, 32'h0,        32'hCAFE0000, 8'hAB};
    vecs[15] = '{1, 4'h4, 32'h0000000F, 4'h1, 32'h0,        32'hCAFE0000, 8'h0F};

    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    resp_ready = 0;
    tick(); tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_disp_data", disp_data, 32'd0);
    chk("rst_disp_blank", {24'b0, disp_blank}, 32'd0);
    rst = 0;
    tick();

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_disp_data", i), disp_data, vecs[i].exp_disp);
      chk($sformatf("vec%0d_disp_blank", i), {24'b0, disp_blank}, {24'b0, vecs[i].exp_blank});
    end

    // Blink: CTRL=1 accepted at edge N; phase after edge N+j is (j/4)%2 and
    // blank after edge N+i reflects the phase after edge N+i-1.
    xfer(1, 4'h8, 32'h1, 4'h1, 32'h0);
    for (int i = 1; i <= 14; i++) begin
      chk($sformatf("blink_%0d", i), {24'b0, disp_blank},
          ((((i - 1) / 4) % 2) != 0) ? 32'hFF : 32'h0F);
      if (i < 14) tick();
    end
    xfer(0, 4'hC, 32'h0, 4'h0, 32'h1);          // accepted at N+15, phase after N+14 = 1
    xfer(1, 4'h8, 32'h0, 4'h1, 32'h0);          // blink off
    chk("blink_off_blank", {24'b0, disp_blank}, 32'h0F);
    xfer(0, 4'hC, 32'h0, 4'h0, 32'h0);

    // Backpressure: read DATA held in RESP, next request (MASK) waits.
    req_valid = 1; req_we = 0; req_addr = 4'h0; resp_ready = 0;
    sb.push_back(32'hCAFE0000);
    tick();
    req_addr = 4'h4;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, sb[0]);
      if (i < 4) tick();
    end
    resp_ready = 1;
    void'(sb.pop_front());
    tick();
    chk("bp_release", {30'b0, resp_valid, req_ready}, 32'd1);
    sb.push_back(32'h0000000F);
    tick();
    req_valid = 0;
    chk("bp_second_valid", {31'b0, resp_valid}, 32'd1);
    chk("bp_second_rdata", resp_rdata, sb.pop_front());
    tick();

    // Reset while a write response is outstanding.
    req_valid = 1; req_we = 1; req_addr = 4'h0; req_wdata = 32'h11223344; req_wstrb = 4'hF;
    resp_ready = 0;
    tick();
    req_valid = 0;
    tick(); tick();
    chk("pre_rst_disp", disp_data, 32'h11223344);
    rst = 1;
    #1;
    sb.delete();
    chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_disp_data", disp_data, 32'd0);
    chk("arst_disp_blank", {24'b0, disp_blank}, 32'd0);
    tick();
    rst = 0;
    tick();
    xfer(0, 4'h0, 32'h0, 4'h0, 32'h0);
    xfer(0, 4'h4, 32'h0, 4'h0, 32'h0);
    xfer(0, 4'h8, 32'h0, 4'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
